// File: rtl/maze_tile_renderer.sv
// Tile renderer: walks the pixels of one tile (or the whole grid) and streams
// them to the VGA adapter. Each tile is coloured from a sprite colour, a maze map or black.
module maze_tile_renderer #(
  parameter int TILE    = 4,
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 32,
  parameter int COORD_W = 5,
  parameter int MAPS    = 3,
  parameter int SEL_W   = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COORD_W-1:0]     tile_x,
  input  logic [COORD_W-1:0]     tile_y,
  input  logic [2:0]             sprite_colour,
  input  logic [SEL_W-1:0]       map_sel,
  output logic [2*COORD_W-1:0]   mem_addr,
  input  logic [3*MAPS-1:0]      mem_q,
  output logic [8:0]             vga_x,
  output logic [8:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = (TILE > 1) ? $clog2(TILE) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PAINT = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] OP_DRAW    = 2'b00;
  localparam logic [1:0] OP_SPRITE  = 2'b01;
  localparam logic [1:0] OP_RESTORE = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;

  localparam logic [PW-1:0]      PX_LAST  = PW'(TILE - 1);
  localparam logic [COORD_W-1:0] TX_LAST  = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] TY_LAST  = COORD_W'(GRID_H - 1);
  localparam logic [31:0]        GRID_W_U = 32'(GRID_W);
  localparam logic [31:0]        GRID_H_U = 32'(GRID_H);
  localparam logic [31:0]        MAPS_U   = 32'(MAPS);

  logic [2:0]         state, state_n;
  logic [1:0]         op;
  logic [SEL_W-1:0]   sel;
  logic [COORD_W-1:0] tx, ty, tx_n, ty_n;
  logic [PW-1:0]      px, py, px_n, py_n;
  logic [2:0]         tile_colour, colour_n;
  logic [2*COORD_W-1:0] addr_n;

  logic               target_oob, last_pixel, last_tile;
  logic [2:0]         map_item, map_colour;

  function automatic logic [2:0] palette(input logic [2:0] item);
    case (item)
      3'd0:    return 3'b110;
      3'd1:    return 3'b101;
      3'd2:    return 3'b001;
      3'd3:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // 9-bit arithmetic gives the required modulo-512 truncation directly.
  function automatic logic [8:0] coord(input logic [COORD_W-1:0] t, input logic [PW-1:0] p);
    return 9'(t) * 9'(TILE) + 9'(p);
  endfunction

  assign target_oob = (32'(tile_x) >= GRID_W_U) || (32'(tile_y) >= GRID_H_U);
  assign last_pixel = (px == PX_LAST) && (py == PX_LAST);
  assign last_tile  = (tx == TX_LAST) && (ty == TY_LAST);

  always_comb begin
    map_item = 3'd0;
    for (int unsigned k = 0; k < MAPS; k++) begin
      if (32'(sel) == k) map_item = mem_q[3*k +: 3];
    end
    map_colour = (32'(sel) < MAPS_U) ? palette(map_item) : 3'b000;
  end

  always_comb begin
    state_n  = state;
    tx_n     = tx;
    ty_n     = ty;
    px_n     = px;
    py_n     = py;
    colour_n = tile_colour;
    addr_n   = mem_addr;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          px_n     = '0;
          py_n     = '0;
          colour_n = (cmd_op == OP_SPRITE) ? sprite_colour : 3'b000;
          if (cmd_op == OP_DRAW || cmd_op == OP_CLEAR) begin
            tx_n = '0;
            ty_n = '0;
          end else begin
            tx_n = tile_x;
            ty_n = tile_y;
          end
          addr_n = {ty_n, tx_n};
          case (cmd_op)
            OP_DRAW:    state_n = S_FETCH;
            OP_SPRITE:  state_n = target_oob ? S_DONE : S_PAINT;
            OP_RESTORE: state_n = target_oob ? S_DONE : S_FETCH;
            default:    state_n = S_PAINT;
          endcase
        end
      end
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        colour_n = map_colour;
        px_n     = '0;
        py_n     = '0;
        state_n  = S_PAINT;
      end
      S_PAINT: begin
        if (last_pixel) begin
          state_n = (op == OP_SPRITE || op == OP_RESTORE) ? S_DONE : S_NEXT;
        end else if (px == PX_LAST) begin
          px_n = '0;
          py_n = py + 1'b1;
        end else begin
          px_n = px + 1'b1;
        end
      end
      S_NEXT: begin
        if (last_tile) begin
          state_n = S_DONE;
        end else begin
          if (tx == TX_LAST) begin
            tx_n = '0;
            ty_n = ty + 1'b1;
          end else begin
            tx_n = tx + 1'b1;
          end
          px_n    = '0;
          py_n    = '0;
          addr_n  = {ty_n, tx_n};
          state_n = (op == OP_CLEAR) ? S_PAINT : S_FETCH;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the cycle the state occupies.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      op          <= '0;
      sel         <= '0;
      tx          <= '0;
      ty          <= '0;
      px          <= '0;
      py          <= '0;
      tile_colour <= '0;
      mem_addr    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      vga_plot    <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
    end else begin
      state       <= state_n;
      tx          <= tx_n;
      ty          <= ty_n;
      px          <= px_n;
      py          <= py_n;
      tile_colour <= colour_n;
      mem_addr    <= addr_n;
      cmd_ready   <= (state_n == S_IDLE);
      busy        <= (state_n != S_IDLE);
      done        <= (state_n == S_DONE);
      vga_plot    <= (state_n == S_PAINT);
      if (state == S_IDLE && cmd_valid) begin
        op  <= cmd_op;
        sel <= map_sel;
      end
      if (state_n == S_PAINT) begin
        vga_x      <= coord(tx_n, px_n);
        vga_y      <= coord(ty_n, py_n);
        vga_colour <= colour_n;
      end
    end
  end

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Directed bench for maze_tile_renderer: a default-sized instance and a small
// 20x2 grid with 2-pixel tiles, both checked against a pixel scoreboard.
module tb_maze_tile_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       cv0, cv1, rdy0, rdy1, plot0, plot1, busy0, busy1, done0, done1;
  logic [1:0] op0, op1, sel0, sel1;
  logic [4:0] tx0, ty0, tx1, ty1;
  logic [2:0] col0, col1, c0, c1;
  logic [9:0] addr0, addr1;
  logic [8:0] q0, q1, x0, y0, x1, y1;

  maze_tile_renderer dut0 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_op(op0),
    .tile_x(tx0), .tile_y(ty0), .sprite_colour(col0), .map_sel(sel0),
    .mem_addr(addr0), .mem_q(q0), .vga_x(x0), .vga_y(y0), .vga_colour(c0),
    .vga_plot(plot0), .busy(busy0), .done(done0)
  );

  maze_tile_renderer #(
    .TILE(2), .GRID_W(20), .GRID_H(2), .COORD_W(5), .MAPS(3), .SEL_W(2)
  ) dut1 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_op(op1),
    .tile_x(tx1), .tile_y(ty1), .sprite_colour(col1), .map_sel(sel1),
    .mem_addr(addr1), .mem_q(q1), .vga_x(x1), .vga_y(y1), .vga_colour(c1),
    .vga_plot(plot1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb0[$];
  pix_t sb1[$];
  int total = 0;
  int bad = 0;
  int plots0 = 0;
  int plots1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pal(input int item);
    case (item)
      0:       return 3'b110;
      1:       return 3'b101;
      2:       return 3'b001;
      3:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Map 0: tx mod 8; map 1: (ty - tx) mod 8; map 2: (tx + ty) mod 5.
  function automatic logic [8:0] ram_word(input logic [9:0] a);
    int ix, iy;
    ix = int'(a[4:0]);
    iy = int'(a[9:5]);
    return {3'((ix + iy) % 5), 3'(iy - ix), 3'(ix)};
  endfunction

  always @(posedge clk) begin
    q0 <= ram_word(addr0);
    q1 <= ram_word(addr1);
  end

  always @(negedge clk) begin : mon
    pix_t e;
    if (plot0) begin
      plots0++;
      e = (sb0.size() > 0) ? sb0.pop_front() : '1;
      check("dut0_pixel", 32'({x0, y0, c0}), 32'(e));
    end
    if (plot1) begin
      plots1++;
      e = (sb1.size() > 0) ? sb1.pop_front() : '1;
      check("dut1_pixel", 32'({x1, y1, c1}), 32'(e));
    end
  end

  task automatic push_tile(input int which, input int t, input int tx, input int ty,
                           input logic [2:0] colour);
    pix_t p;
    for (int py = 0; py < t; py++) begin
      for (int px = 0; px < t; px++) begin
        p.x = 9'(tx * t + px);
        p.y = 9'(ty * t + py);
        p.c = colour;
        if (which == 0) sb0.push_back(p);
        else            sb1.push_back(p);
      end
    end
  endtask

  task automatic issue(input int which, input logic [1:0] op, input int tx, input int ty,
                       input logic [2:0] col, input logic [1:0] sel);
    @(negedge clk);
    if (which == 0) begin
      cv0 = 1'b1; op0 = op; tx0 = 5'(tx); ty0 = 5'(ty); col0 = col; sel0 = sel;
      check("dut0_ready_at_accept", 32'(rdy0), 32'd1);
    end else begin
      cv1 = 1'b1; op1 = op; tx1 = 5'(tx); ty1 = 5'(ty); col1 = col; sel1 = sel;
      check("dut1_ready_at_accept", 32'(rdy1), 32'd1);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the captured values must be used.
    if (which == 0) begin
      cv0 = 1'b0; tx0 = ~tx0; ty0 = ~ty0; col0 = ~col0; sel0 = ~sel0;
    end else begin
      cv1 = 1'b0; tx1 = ~tx1; ty1 = ~ty1; col1 = ~col1; sel1 = ~sel1;
    end
  endtask

  task automatic wait_done(input int which, input string tag, input int exp_cyc,
                           input int limit, input int addr_exp, input bit poke);
    int seen = 0;
    for (int n = 1; n <= limit && seen == 0; n++) begin
      @(negedge clk);
      if (n == 1 && addr_exp >= 0)
        check({tag, "_mem_addr"}, 32'(which ? addr1 : addr0), 32'(addr_exp));
      if (poke) begin
        cv0 = (n >= 2 && n <= 4);
        op0 = 2'b11;
      end
      if (which ? done1 : done0) begin
        seen = n;
        check({tag, "_busy_at_done"}, 32'(which ? busy1 : busy0), 32'd1);
        check({tag, "_ready_at_done"}, 32'(which ? rdy1 : rdy0), 32'd0);
      end
    end
    check({tag, "_done_cycle"}, 32'(seen), 32'(exp_cyc));
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(which ? rdy1 : rdy0), 32'd1);
    check({tag, "_busy_after"}, 32'(which ? busy1 : busy0), 32'd0);
    check({tag, "_done_pulse"}, 32'(which ? done1 : done0), 32'd0);
  endtask

  initial begin
    int start;
    resetn = 1'b0;
    cv0 = 0; op0 = 0; tx0 = 0; ty0 = 0; col0 = 0; sel0 = 0;
    cv1 = 0; op1 = 0; tx1 = 0; ty1 = 0; col1 = 0; sel1 = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_plot", 32'(plot0), 32'd0);
    check("rst_xy", 32'({x0, y0}), 32'd0);
    check("rst_colour", 32'(c0), 32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_ready_small", 32'(rdy1), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(rdy0), 32'd1);
    check("post_rst_busy", 32'(busy0), 32'd0);

    // SPRITE (5,2) with cmd_valid pokes while busy
    push_tile(0, 4, 5, 2, 3'b001);
    issue(0, 2'b01, 5, 2, 3'b001, 2'd0);
    wait_done(0, "sprite", 17, 40, -1, 1'b1);
    check("sprite_sb_empty", 32'(sb0.size()), 32'd0);

    // RESTORE (3,4) map 1 -> item 1 -> 101
    push_tile(0, 4, 3, 4, 3'b101);
    issue(0, 2'b10, 3, 4, 3'b000, 2'd1);
    wait_done(0, "restore", 19, 40, 4 * 32 + 3, 1'b0);

    // RESTORE with map_sel beyond MAPS -> black
    push_tile(0, 4, 6, 1, 3'b000);
    issue(0, 2'b10, 6, 1, 3'b000, 2'd3);
    wait_done(0, "restore_badsel", 19, 40, 1 * 32 + 6, 1'b0);

    // DRAW_MAZE from map 2
    for (int ty = 0; ty < 32; ty++)
      for (int tx = 0; tx < 32; tx++)
        push_tile(0, 4, tx, ty, pal((tx + ty) % 5));
    start = plots0;
    issue(0, 2'b00, 0, 0, 3'b000, 2'd2);
    wait_done(0, "draw", 19457, 20000, 0, 1'b0);
    check("draw_plot_count", 32'(plots0 - start), 32'd16384);
    check("draw_last_xy", 32'({x0, y0}), 32'({9'd127, 9'd127}));
    check("draw_sb_empty", 32'(sb0.size()), 32'd0);

    // Small grid: out-of-range SPRITE and RESTORE
    start = plots1;
    issue(1, 2'b01, 31, 0, 3'b111, 2'd0);
    wait_done(1, "oob_sprite", 1, 10, -1, 1'b0);
    issue(1, 2'b10, 0, 2, 3'b000, 2'd0);
    wait_done(1, "oob_restore", 1, 10, -1, 1'b0);
    check("oob_plot_count", 32'(plots1 - start), 32'd0);

    // Small grid: edge tile sprite, full CLEAR, RESTORE map 0
    push_tile(1, 2, 19, 1, 3'b011);
    issue(1, 2'b01, 19, 1, 3'b011, 2'd0);
    wait_done(1, "small_sprite", 5, 20, -1, 1'b0);
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 20; tx++)
        push_tile(1, 2, tx, ty, 3'b000);
    issue(1, 2'b11, 7, 1, 3'b111, 2'd0);
    wait_done(1, "clear", 201, 300, -1, 1'b0);
    push_tile(1, 2, 2, 1, 3'b001);
    issue(1, 2'b10, 2, 1, 3'b000, 2'd0);
    wait_done(1, "small_restore", 7, 20, 1 * 32 + 2, 1'b0);
    check("small_sb_empty", 32'(sb1.size()), 32'd0);

    // Abort a SPRITE during plot 7
    push_tile(0, 4, 1, 1, 3'b111);
    start = plots0;
    issue(0, 2'b01, 1, 1, 3'b111, 2'd0);
    for (int i = 0; i < 30 && (plots0 - start) < 7; i++) begin
      @(negedge clk);
      #1;
    end
    check("abort_reached_plot7", 32'(plots0 - start), 32'd7);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_plot", 32'(plot0), 32'd0);
    check("abort_ready", 32'(rdy0), 32'd1);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_x", 32'(x0), 32'd0);
    check("abort_pending", 32'(sb0.size()), 32'd9);
    sb0.delete();
    resetn = 1'b1;

    // Accepted on the first edge after reset release; corner tile (31,31), map 2
    push_tile(0, 4, 31, 31, 3'b001);
    issue(0, 2'b10, 31, 31, 3'b000, 2'd2);
    wait_done(0, "reaccept", 19, 40, 31 * 32 + 31, 1'b0);
    check("final_sb0_empty", 32'(sb0.size()), 32'd0);
    check("final_sb1_empty", 32'(sb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
